// File: rtl/sha256_w_sched_ctrl.sv
// sha256_w_sched_ctrl
// Iterative SHA-256 message-schedule sequencer. Captures one 512-bit block,
// then streams W0..W(NUM_WORDS-1), one word per accepted cycle. A 16-word
// rolling window holds W(t)..W(t+15), and the sigma0/sigma1 expansion is
// applied to it internally.
//
// Optional feature macro: SHA256_W_BACKPRESSURE_EN
//   defined   : w_ready is honoured and the consumer may stall the stream.
//   undefined : w_ready is ignored (tie it high) and the block emits a fixed
//               unstalled burst. The stall logic is not built.
//
// Handshake: a word transfers on a rising CLK edge when w_valid and w_ready
// are both high. With backpressure disabled, w_valid alone is enough. While
// w_valid is high and the word has not been accepted, w_out and w_idx do not
// change. The only exits are acceptance, abort and RST.
module sha256_w_sched_ctrl #(
   parameter int NUM_WORDS = 64,
   parameter int IDX_W     = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic             abort,
   input  logic [511:0]     block_in,
   input  logic             w_ready,
   output logic [31:0]      w_out,
   output logic [IDX_W-1:0] w_idx,
   output logic             w_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic [15:0][31:0]     win_q;
   logic [15:0][31:0]     win_d;
   logic [IDX_W-1:0]      t_q;
   logic [IDX_W-1:0]      t_d;
   logic                  run_st;
   logic                  accept;
   logic                  last_word;
   logic [31:0]           w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   assign run_st    = (state_q == ST_RUN);
   assign last_word = (t_q == IDX_W'(NUM_WORDS - 1));

   // Next word entering the top of the window. It is computed on every
   // shift, but it only matters from t=16 onward.
   assign w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

`ifdef SHA256_W_BACKPRESSURE_EN
   assign accept = run_st & w_ready;
`else
   // w_ready is kept in the port list but has no effect in this build.
   logic unused_w_ready;
   assign unused_w_ready = w_ready;
   assign accept = run_st;
`endif

   // State register; async reset returns to IDLE immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: abort beats accept, start only matters in IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (abort)                       state_d = ST_IDLE;
            else if (accept && last_word)    state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode: outputs are zero outside RUN, and done is a DONE-state pulse.
   always_comb begin
      w_valid = 1'b0;
      w_out   = '0;
      w_idx   = '0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         ST_RUN: begin
            w_valid = 1'b1;
            w_out   = win_q[0];
            w_idx   = t_q;
            busy    = 1'b1;
         end
         ST_DONE: begin
            busy = 1'b1;
            // An abort in the DONE cycle cancels the completion pulse.
            done = ~abort;
         end
         default: begin
         end
      endcase
   end

   // Window and index next-state: load on start, shift on accept, hold otherwise.
   always_comb begin
      win_d = win_q;
      t_d   = t_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               for (int i = 0; i < 16; i++) begin
                  win_d[i] = block_in[511 - 32*i -: 32];
               end
               t_d = '0;
            end
         end
         ST_RUN: begin
            if (abort) begin
               t_d = '0;
            end else if (accept) begin
               for (int i = 0; i < 15; i++) begin
                  win_d[i] = win_q[i+1];
               end
               win_d[15] = w_new;
               // Clear t at the last word rather than letting it wrap.
               t_d = last_word ? '0 : t_q + IDX_W'(1);
            end
         end
         default: begin
            t_d = '0;
         end
      endcase
   end

   // Window and index registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         win_q <= '0;
         t_q   <= '0;
      end else begin
         win_q <= win_d;
         t_q   <= t_d;
      end
   end

endmodule

// File: doc/sha256_w_sched_ctrl.md
Name: sha256_w_sched_ctrl

Overview:
Iterative message-schedule sequencer for the SHA-256 compression core. It captures one 512-bit block, then streams W0..W63 one word per accepted cycle under a valid/ready handshake. It holds a 16-word rolling window and applies the σ0/σ1 expansion internally. It sits between the block/nonce formatter and the round engine, and replaces the unrolled W-memory stages in area-optimised variants.

Parameters:
NUM_WORDS, 64, number of W words emitted per block (valid range 16..64)
IDX_W, 6, width of the word index output; must satisfy 2^IDX_W >= NUM_WORDS

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  asynchronous, active-high reset
start  input  1  request to load block_in; sampled only in IDLE
abort  input  1  synchronous cancel of the current block
block_in  input  512  message block; W0 in [511:480], W15 in [31:0]
w_ready  input  1  consumer accepts w_out this cycle (used only with the macro)
w_out  output  32  current schedule word W_t
w_idx  output  IDX_W  index t of w_out
w_valid  output  1  w_out and w_idx are valid
busy  output  1  high in LOAD-free states RUN and DONE
done  output  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, RST=1): state=IDLE; window cleared to 0; t=0; w_out=0, w_idx=0, w_valid=0, busy=0, done=0. Takes effect immediately, including mid-block. No partial output after release.
- States:
  - IDLE: start=1 captures block_in into window[0..15] (window[0]=W0); t=0; next state RUN. Otherwise hold.
  - RUN: w_valid=1, w_out=window[0], w_idx=t.
    - Accept = w_valid & w_ready.
    - On accept: shift the window down one word. window[15] <= σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32. t <= t+1.
    - Accept with t==NUM_WORDS-1: next state DONE.
  - DONE: w_valid=0; done=1 for exactly this cycle; next state IDLE.
- Expansion functions:
  - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
  - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
  - All additions are 32-bit and discard the carry.
- Latency and throughput:
  - start sampled at edge N; first w_valid in cycle N+1.
  - With no stalls: 64 consecutive valid cycles, done in cycle N+65, IDLE at N+66.
  - Next start is accepted in cycle N+66, giving 66 cycles per block.
- Stall: with w_ready=0, w_out, w_idx and the window are held unchanged; w_valid stays 1. The valid word must never change while unaccepted.
- Words 0..15 are emitted straight from the captured block. The expansion result is only produced for t>=16 but is computed every shift; this is harmless.
- abort:
  - In RUN or DONE: next state IDLE, w_valid=0, no done pulse, t=0.
  - In IDLE: ignored.
  - abort overrides a simultaneous accept.
  - If abort and start arrive together in IDLE, start wins (abort is ignored in IDLE).
- start while busy: ignored, never queued.
- busy=1 exactly in RUN and DONE.
- t never wraps: the RUN→DONE transition occurs at NUM_WORDS-1.

Optional Feature:
Macro: SHA256_W_BACKPRESSURE_EN
- Defined: the w_ready port is honoured as described above.
- Undefined:
  - w_ready is ignored; accept = w_valid every cycle, so the block emits a fixed 64-cycle burst.
  - The port remains in the port list and must be tied to 1 by the integrator.
  - Stall logic is compiled out.

Test Plan:
- "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018), no stalls -> W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB; all 64 words match the C model; done at cycle start+65.
- Random w_ready=0 stalls (macro on), including a stall at t=63 -> word sequence identical to the no-stall run; w_out/w_idx stable while stalled; exactly one done pulse.
- abort asserted at t=20 -> w_valid=0 next cycle, no done; a following start produces a correct full stream from W0.
- RST pulsed asynchronously mid-RUN (t=40) -> outputs zero immediately; after release the block stays IDLE until start.
- start held high throughout two back-to-back blocks -> second block loads only in IDLE (66-cycle spacing); start pulses during RUN are ignored.
- Macro off, w_ready=0 -> 64-cycle stream still completes unstalled with correct values.
